// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM state codes
// and lane-mask / alignment classification helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t IDLE = 2'd0;
  localparam lsu_state_t ST1  = 2'd1;
  localparam lsu_state_t LD0  = 2'd2;
  localparam lsu_state_t LD1  = 2'd3;

  // Encoding 11 is treated as a word access everywhere.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_HALF: size_mask = 4'b0011;
      SZ_BYTE: size_mask = 4'b0001;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_word(input logic [1:0] sz);
    is_word = (sz != SZ_HALF) && (sz != SZ_BYTE);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    is_misaligned = ((sz == SZ_HALF) && off[0]) || (is_word(sz) && (off != 2'd0));
  endfunction

  function automatic logic is_crossing(input logic [1:0] sz, input logic [1:0] off);
    is_crossing = ((sz == SZ_HALF) && (off == 2'd3)) || (is_word(sz) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: rotates the addressed bytes down to lane 0, then masks to
// the access size and sign- or zero-extends.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size_src,
  input  logic        load_sign,
  output logic [31:0] result
);

  logic [31:0] rot;

  always_comb begin
    case (off)
      2'd1:    rot = {word[7:0],  word[31:8]};
      2'd2:    rot = {word[15:0], word[31:16]};
      2'd3:    rot = {word[23:0], word[31:24]};
      default: rot = word;
    endcase
  end

  always_comb begin
    case (size_src)
      SZ_BYTE: result = {{24{load_sign & rot[7]}}, rot[7:0]};
      SZ_HALF: result = {{16{load_sign & rot[15]}}, rot[15:0]};
      default: result = rot;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: drives a word-wide synchronous RAM with byte lanes
// and returns extended load data. Define LSU_MISALIGNED_EN to split
// word-crossing accesses into two beats; otherwise misaligned accesses are flagged.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic [1:0]        size_src,
  input  logic              load_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              misaligned,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd1:    rotl_bytes = {w[23:0], w[31:24]};
      2'd2:    rotl_bytes = {w[15:0], w[31:16]};
      2'd3:    rotl_bytes = {w[7:0],  w[31:8]};
      default: rotl_bytes = w;
    endcase
  endfunction

  // Lanes owned by the lower beat come from the hold register, the rest from the upper beat.
  function automatic logic [31:0] merge_beats(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [3:0] lo_be);
    for (int i = 0; i < 4; i++) begin
      merge_beats[8*i +: 8] = lo_be[i] ? lo[8*i +: 8] : hi[8*i +: 8];
    end
  endfunction

  lsu_state_t        state_q;
  lsu_state_t        state_next;

  logic [1:0]        off;
  logic [7:0]        be_wide;
  logic [3:0]        lower_be;
  logic [3:0]        upper_be;
  logic [31:0]       wdata_rot;
  logic              req_cross;
  logic              mis_flag;

  logic [ADDR_W-3:0] word_addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              cross_q;
  logic              mis_q;
  logic [3:0]        lower_be_q;
  logic [3:0]        upper_be_q;
  logic [31:0]       wdata_rot_q;
  logic [31:0]       hold_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              capture_hold;
  logic [31:0]       align_word;
  logic [31:0]       align_out;
  logic [31:0]       formatted;

  assign off       = addr[1:0];
  assign be_wide   = {4'b0000, size_mask(size_src)} << off;
  assign lower_be  = be_wide[3:0];
  assign upper_be  = be_wide[7:4];
  assign wdata_rot = rotl_bytes(wdata, off);

`ifdef LSU_MISALIGNED_EN
  assign req_cross = is_crossing(size_src, off);
  assign mis_flag  = 1'b0;
`else
  assign req_cross = 1'b0;
  assign mis_flag  = is_misaligned(size_src, off);
`endif

  assign misaligned = !rst && (state_q == IDLE) && req_valid && mis_flag;

  always_comb begin
    state_next   = state_q;
    stall        = 1'b0;
    rdata_valid  = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_addr     = '0;
    mem_wdata    = '0;
    accept       = 1'b0;
    capture_hold = 1'b0;
    align_word   = mem_rdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          mem_addr = addr[ADDR_W-1:2];
          mem_be   = lower_be;
          if (mem_write) begin
            mem_wdata = wdata_rot;
            mem_we    = !mis_flag;
            if (req_cross) begin
              stall      = 1'b1;
              state_next = ST1;
            end
          end else begin
            stall      = 1'b1;
            state_next = LD0;
          end
        end
      end
      ST1: begin
        mem_addr   = word_addr_q + WORD_ONE;
        mem_be     = upper_be_q;
        mem_wdata  = wdata_rot_q;
        mem_we     = 1'b1;
        state_next = IDLE;
      end
      LD0: begin
        if (cross_q) begin
          mem_addr     = word_addr_q + WORD_ONE;
          mem_be       = upper_be_q;
          capture_hold = 1'b1;
          stall        = 1'b1;
          state_next   = LD1;
        end else begin
          rdata_valid = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        align_word  = merge_beats(hold_q, mem_rdata, lower_be_q);
        rdata_valid = 1'b1;
        state_next  = IDLE;
      end
    endcase
    // A reset cycle abandons any access in flight: no beat, no result.
    if (rst) begin
      stall       = 1'b0;
      rdata_valid = 1'b0;
      mem_we      = 1'b0;
      mem_be      = 4'b0000;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

  lsu_load_align u_align (
    .word      (align_word),
    .off       (off_q),
    .size_src  (size_q),
    .load_sign (sign_q),
    .result    (align_out)
  );

  assign formatted = mis_q ? 32'd0 : align_out;
  assign rdata     = rdata_valid ? formatted : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_next;
      if (capture_hold) hold_q <= mem_rdata;
      if (rdata_valid) rdata_q <= formatted;
    end
  end

  // Request snapshot taken in IDLE; later beats use it instead of the held inputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_addr_q <= addr[ADDR_W-1:2];
      off_q       <= off;
      size_q      <= size_src;
      sign_q      <= load_sign;
      cross_q     <= req_cross;
      mis_q       <= mis_flag;
      lower_be_q  <= lower_be;
      upper_be_q  <= upper_be;
      wdata_rot_q <= wdata_rot;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a load-result
// scoreboard, a byte-lane RAM model, and hand sequences for reset and crossing beats.
module tb_load_store_unit;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size_src = 2'b00;
  logic        load_sign = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        misaligned;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
    .size_src(size_src), .load_sign(load_sign), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall), .misaligned(misaligned),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:255];
  logic        init_ram = 1'b1;

  always @(posedge clk) begin
    if (init_ram) begin
      ram[8'h40] <= 32'h1280_FF34;
      ram[8'h41] <= 32'h0000_0000;
      ram[8'h50] <= 32'h8001_7FFE;
      ram[8'h80] <= 32'h0000_0000;
      ram[8'h81] <= 32'h1122_3344;
    end else begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdata_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdata_valid: got rdata %h, expected no result", rdata);
      end else begin
        check("rdata", rdata, sb.pop_front());
      end
    end
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic        exp_mis;
    int          exp_stalls;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t ld(input string n, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] a, input logic [31:0] exp_rd,
                              input logic mis, input int st);
    vec_t v;
    v.name = n; v.wr = 1'b0; v.sz = sz; v.sgn = sgn; v.a = a; v.wd = 32'd0;
    v.exp_rd = exp_rd; v.exp_we = 1'b0; v.exp_be = 4'd0; v.exp_wd = 32'd0;
    v.exp_mis = mis; v.exp_stalls = st;
    return v;
  endfunction

  function automatic vec_t st(input string n, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic we, input logic [3:0] be,
                              input logic [31:0] ewd, input logic mis);
    vec_t v;
    v.name = n; v.wr = 1'b1; v.sz = sz; v.sgn = 1'b0; v.a = a; v.wd = wd;
    v.exp_rd = 32'd0; v.exp_we = we; v.exp_be = be; v.exp_wd = ewd;
    v.exp_mis = mis; v.exp_stalls = 0;
    return v;
  endfunction

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; mem_write = wr; size_src = sz; load_sign = sgn; addr = a; wdata = wd;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_valid = 1'b0; mem_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    drive(v.wr, v.sz, v.sgn, v.a, v.wd);
    if (!v.wr) begin
      sb.push_back(v.exp_rd);
      last_rd = v.exp_rd;
    end
    @(negedge clk);
    check({v.name, " misaligned"}, {31'd0, misaligned}, {31'd0, v.exp_mis});
    check({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
    check({v.name, " mem_addr"}, {2'b00, mem_addr}, {2'b00, v.a[31:2]});
    if (v.wr && v.exp_we) begin
      check({v.name, " mem_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
      check({v.name, " mem_wdata"}, mem_wdata, v.exp_wd);
    end
    while (stall) begin
      stalls++;
      if (stalls > 4) begin
        tests++;
        fails++;
        $display("FAIL %s stall_timeout: got stall after %0d cycles, expected release", v.name, stalls);
        break;
      end
      @(negedge clk);
      check({v.name, " misaligned_late"}, {31'd0, misaligned}, 32'd0);
      check({v.name, " mem_we_late"}, {31'd0, mem_we}, 32'd0);
    end
    check({v.name, " stalls"}, stalls, v.exp_stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back(ld("lb_s_102", B, 1'b1, 32'h102, 32'hFFFF_FF80, 1'b0, 1));
    vecs.push_back(ld("lb_u_102", B, 1'b0, 32'h102, 32'h0000_0080, 1'b0, 1));
    vecs.push_back(ld("lb_s_103", B, 1'b1, 32'h103, 32'h0000_0012, 1'b0, 1));
    vecs.push_back(ld("lb_s_101", B, 1'b1, 32'h101, 32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(ld("lb_u_100", B, 1'b0, 32'h100, 32'h0000_0034, 1'b0, 1));
    vecs.push_back(ld("lh_s_100", H, 1'b1, 32'h100, 32'hFFFF_FF34, 1'b0, 1));
    vecs.push_back(ld("lh_u_102", H, 1'b0, 32'h102, 32'h0000_1280, 1'b0, 1));
    vecs.push_back(ld("lh_s_142", H, 1'b1, 32'h142, 32'hFFFF_8001, 1'b0, 1));
    vecs.push_back(ld("lh_s_140", H, 1'b1, 32'h140, 32'h0000_7FFE, 1'b0, 1));
    vecs.push_back(ld("lw_140",   W, 1'b0, 32'h140, 32'h8001_7FFE, 1'b0, 1));
    vecs.push_back(ld("lw_sz3",   2'b11, 1'b1, 32'h100, 32'h1280_FF34, 1'b0, 1));
    vecs.push_back(st("sh_206", H, 32'h206, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEF_0000, 1'b0));
    vecs.push_back(st("sb_205", B, 32'h205, 32'h0000_00AB, 1'b1, 4'b0010, 32'h0000_AB00, 1'b0));
    vecs.push_back(st("sw_200", W, 32'h200, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0));
    vecs.push_back(ld("lw_204",   W, 1'b0, 32'h204, 32'hBEEF_AB44, 1'b0, 1));
    vecs.push_back(ld("lw_200",   W, 1'b0, 32'h200, 32'hCAFE_F00D, 1'b0, 1));
    vecs.push_back(st("sb_203", B, 32'h203, 32'h1234_5677, 1'b1, 4'b1000, 32'h7712_3456, 1'b0));
    vecs.push_back(ld("lw_200b",  W, 1'b0, 32'h200, 32'h77FE_F00D, 1'b0, 1));
    vecs.push_back(st("sw_100", W, 32'h100, 32'h4433_2211, 1'b1, 4'b1111, 32'h4433_2211, 1'b0));
    vecs.push_back(st("sw_104", W, 32'h104, 32'h8877_6655, 1'b1, 4'b1111, 32'h8877_6655, 1'b0));
    vecs.push_back(ld("lw_100",   W, 1'b0, 32'h100, 32'h4433_2211, 1'b0, 1));
    vecs.push_back(ld("lb_u_107", B, 1'b0, 32'h107, 32'h0000_0088, 1'b0, 1));
`ifdef LSU_MISALIGNED_EN
    vecs.push_back(ld("lh_s_101", H, 1'b1, 32'h101, 32'h0000_3322, 1'b0, 1));
    vecs.push_back(ld("lw_x_101", W, 1'b0, 32'h101, 32'h5544_3322, 1'b0, 2));
    vecs.push_back(ld("lh_x_103", H, 1'b1, 32'h103, 32'h0000_5544, 1'b0, 2));
`else
    vecs.push_back(st("sw_m_102", W, 32'h102, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 1'b1));
    vecs.push_back(st("sh_m_101", H, 32'h101, 32'h0000_BEEF, 1'b0, 4'b0000, 32'h0, 1'b1));
    vecs.push_back(st("sw_m_106", W, 32'h106, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 1'b1));
    vecs.push_back(ld("lw_m_101", W, 1'b0, 32'h101, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(ld("lh_m_103", H, 1'b1, 32'h103, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(ld("lh_m_101", H, 1'b1, 32'h101, 32'h0000_0000, 1'b1, 1));
    vecs.push_back(ld("lw_100_kept", W, 1'b0, 32'h100, 32'h4433_2211, 1'b0, 1));
    vecs.push_back(ld("lw_104_kept", W, 1'b0, 32'h104, 32'h8877_6655, 1'b0, 1));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst misaligned", {31'd0, misaligned}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_ram = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    go_idle();
    @(negedge clk);
    check("hold rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("hold rdata", rdata, last_rd);

`ifdef LSU_MISALIGNED_EN
    @(posedge clk); #1;
    drive(1'b1, W, 1'b0, 32'h103, 32'hAABB_CCDD);
    @(negedge clk);
    check("swx beat1 stall", {31'd0, stall}, 32'd1);
    check("swx beat1 mem_we", {31'd0, mem_we}, 32'd1);
    check("swx beat1 mem_be", {28'd0, mem_be}, 32'b1000);
    check("swx beat1 mem_addr", {2'b00, mem_addr}, 32'h40);
    check("swx beat1 mem_wdata", mem_wdata, 32'hDDAA_BBCC);
    @(negedge clk);
    check("swx beat2 stall", {31'd0, stall}, 32'd0);
    check("swx beat2 mem_we", {31'd0, mem_we}, 32'd1);
    check("swx beat2 mem_be", {28'd0, mem_be}, 32'b0111);
    check("swx beat2 mem_addr", {2'b00, mem_addr}, 32'h41);
    check("swx beat2 mem_wdata", mem_wdata, 32'hDDAA_BBCC);
    run_vec(ld("lw_100_after_swx", W, 1'b0, 32'h100, 32'hDD33_2211, 1'b0, 1));
    run_vec(ld("lw_104_after_swx", W, 1'b0, 32'h104, 32'h88AA_BBCC, 1'b0, 1));
`endif

    // Reset asserted while the load is waiting in LD0
    @(posedge clk); #1;
`ifdef LSU_MISALIGNED_EN
    drive(1'b0, W, 1'b0, 32'h101, 32'd0);
`else
    drive(1'b0, W, 1'b0, 32'h104, 32'd0);
`endif
    @(negedge clk);
    check("rstld issue stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstld rdata_valid", {31'd0, rdata_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("post_rst stall", {31'd0, stall}, 32'd0);
    check("post_rst rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("post_rst mem_we", {31'd0, mem_we}, 32'd0);
    check("post_rst misaligned", {31'd0, misaligned}, 32'd0);
    check("post_rst rdata", rdata, 32'd0);
    check("post_rst mem_be", {28'd0, mem_be}, 32'd0);
    check("post_rst mem_addr", {2'b00, mem_addr}, 32'd0);
    repeat (3) @(negedge clk);

`ifdef LSU_MISALIGNED_EN
    run_vec(ld("lw_104_recover", W, 1'b0, 32'h104, 32'h88AA_BBCC, 1'b0, 1));
`else
    run_vec(ld("lw_104_recover", W, 1'b0, 32'h104, 32'h8877_6655, 1'b0, 1));
`endif
    go_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
